ram_arbiter: RTL

Shares the single SDRAM controller port between three requesters in the 133 MHz domain: the VGA row-buffer reader, the camera frame writer and the HDR engine (read/write). Each requester gets a one-entry holding register and a `busy` flag, so it can use the same protocol the VGA row buffer already uses: check busy, pulse one request. Issue priority is VGA first, then round-robin between camera and HDR. An in-order tag FIFO routes each `mem_rd_valid` beat back to the requester that issued the read.

---
 rtl/ram_pkg.sv | 19 +
 rtl/tag_fifo.sv | 64 ++++++
 rtl/ram_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the SDRAM port arbiter in the 133 MHz domain.
//   - source ids carried through the read tag FIFO
//   - default SDRAM address / burst data widths
//   - word base addresses of the frame buffers in SDRAM
package ram_pkg;

    localparam logic [1:0] SRC_VGA = 2'd0;
    localparam logic [1:0] SRC_CAM = 2'd1;
    localparam logic [1:0] SRC_HDR = 2'd2;

    localparam int RAM_ADDR_W = 25;
    localparam int RAM_DATA_W = 128;

    // Frame buffers are 0xBB800 words apart.
    localparam logic [RAM_ADDR_W-1:0] FB0_BASE = 25'h000_0000;
    localparam logic [RAM_ADDR_W-1:0] FB1_BASE = 25'h00B_B800;
    localparam logic [RAM_ADDR_W-1:0] HDR_BASE = 25'h017_7000;

endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of 2-bit source ids for outstanding SDRAM reads.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_data   write one tag (caller never pushes into a full FIFO
//                     unless it pops in the same cycle)
//   pop               discard the head (ignored when empty)
//   pop_data          current head, valid when empty = 0
//   full, empty       occupancy flags
module tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    assign do_pop   = pop & ~empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SDRAM controller command port between the VGA row
// reader, the camera frame writer and the HDR engine.
// Ports:
//   clk_133M, rst_n_133M            clock, async active-low reset
//   vga_rd_req/_address, vga_busy   VGA read request, holding-register full
//   vga_rd_valid                    returned beat belongs to VGA
//   cam_wr_req/_address/_data       camera write request
//   cam_busy                        camera holding register full
//   hdr_req/_we/_address/_wr_data   HDR read or write request
//   hdr_busy, hdr_rd_valid          HDR busy, returned beat belongs to HDR
//   rd_data                         mem_rd_data passed through
//   mem_req/_we/_address/_wr_data   registered command to the controller
//   mem_busy                        controller cannot take a command
//   mem_rd_valid/_data              read beat returning
//   tag_err                         sticky: read beat with no tag outstanding
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int TAG_DEPTH = 8,
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W
) (
    input  logic              clk_133M,
    input  logic              rst_n_133M,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_address,
    output logic              vga_busy,
    output logic              vga_rd_valid,
    input  logic              cam_wr_req,
    input  logic [ADDR_W-1:0] cam_wr_address,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              cam_busy,
    input  logic              hdr_req,
    input  logic              hdr_we,
    input  logic [ADDR_W-1:0] hdr_address,
    input  logic [DATA_W-1:0] hdr_wr_data,
    output logic              hdr_busy,
    output logic              hdr_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_busy,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tag_err
);

    logic              vga_pending, cam_pending, hdr_pending;
    logic [ADDR_W-1:0] vga_addr_q, cam_addr_q, hdr_addr_q;
    logic [DATA_W-1:0] cam_data_q, hdr_data_q;
    logic              hdr_we_q;
    logic              rr_hdr;     // 0: camera wins a tie, 1: HDR wins a tie
    logic              fifo_full, fifo_empty;
    logic [1:0]        head_src;
    logic              tag_push, tag_pop;
    logic              vga_elig, cam_elig, hdr_elig, can_issue, contested;
    logic              sel_vga, sel_cam, sel_hdr;

    assign vga_elig  = vga_pending & ~fifo_full;
    assign cam_elig  = cam_pending;
    assign hdr_elig  = hdr_pending & (hdr_we_q | ~fifo_full);
    // mem_req is the registered "issued last cycle" flag, which spaces
    // commands so the controller's mem_busy is fresh for every decision.
    assign can_issue = ~mem_busy & ~mem_req;
    assign contested = cam_elig & hdr_elig;

    always_comb begin
        sel_vga = 1'b0;
        sel_cam = 1'b0;
        sel_hdr = 1'b0;
        if (can_issue) begin
            if (vga_elig) begin
                sel_vga = 1'b1;
            end else if (contested) begin
                sel_hdr = rr_hdr;
                sel_cam = ~rr_hdr;
            end else if (cam_elig) begin
                sel_cam = 1'b1;
            end else if (hdr_elig) begin
                sel_hdr = 1'b1;
            end
        end
    end

    assign tag_push     = sel_vga | (sel_hdr & ~hdr_we_q);
    assign tag_pop      = mem_rd_valid & ~fifo_empty;
    assign vga_rd_valid = tag_pop & (head_src == SRC_VGA);
    assign hdr_rd_valid = tag_pop & (head_src == SRC_HDR);
    assign rd_data      = mem_rd_data;

    assign vga_busy = vga_pending | fifo_full;
    assign cam_busy = cam_pending;
    // When not pending, the next HDR request is a read if hdr_we is low now.
    assign hdr_busy = hdr_pending | (fifo_full & ~hdr_we);

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk_133M),
        .rst_n     (rst_n_133M),
        .push      (tag_push),
        .push_data (sel_vga ? SRC_VGA : SRC_HDR),
        .pop       (mem_rd_valid),
        .pop_data  (head_src),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Holding registers. Capture needs pending = 0 and issue needs
    // pending = 1, so the two never collide on one edge.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            vga_pending <= 1'b0;
            cam_pending <= 1'b0;
            hdr_pending <= 1'b0;
            vga_addr_q  <= '0;
            cam_addr_q  <= '0;
            hdr_addr_q  <= '0;
            cam_data_q  <= '0;
            hdr_data_q  <= '0;
            hdr_we_q    <= 1'b0;
        end else begin
            if (vga_rd_req && !vga_pending) begin
                vga_pending <= 1'b1;
                vga_addr_q  <= vga_rd_address;
            end else if (sel_vga) begin
                vga_pending <= 1'b0;
            end
            if (cam_wr_req && !cam_pending) begin
                cam_pending <= 1'b1;
                cam_addr_q  <= cam_wr_address;
                cam_data_q  <= cam_wr_data;
            end else if (sel_cam) begin
                cam_pending <= 1'b0;
            end
            if (hdr_req && !hdr_pending) begin
                hdr_pending <= 1'b1;
                hdr_we_q    <= hdr_we;
                hdr_addr_q  <= hdr_address;
                hdr_data_q  <= hdr_wr_data;
            end else if (sel_hdr) begin
                hdr_pending <= 1'b0;
            end
        end
    end

    // Command register, round-robin pointer and tag error flag.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wr_data <= '0;
            rr_hdr      <= 1'b0;
            tag_err     <= 1'b0;
        end else begin
            mem_req <= sel_vga | sel_cam | sel_hdr;
            if (sel_vga) begin
                mem_we      <= 1'b0;
                mem_address <= vga_addr_q;
                mem_wr_data <= '0;
            end else if (sel_cam) begin
                mem_we      <= 1'b1;
                mem_address <= cam_addr_q;
                mem_wr_data <= cam_data_q;
            end else if (sel_hdr) begin
                mem_we      <= hdr_we_q;
                mem_address <= hdr_addr_q;
                mem_wr_data <= hdr_data_q;
            end
            // Rotate only when camera and HDR actually competed; an
            // uncontested win leaves the tie-break where it was.
            if ((sel_cam | sel_hdr) && contested) begin
                rr_hdr <= ~rr_hdr;
            end
            if (mem_rd_valid && fifo_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule
